// File: rtl/cdc_xfer_arbiter_if.sv
// cdc_xfer_arbiter_if: requester and clock-crossing channel signals of the arbiter
interface cdc_xfer_arbiter_if #(
    parameter int num_requesters = 4,
    parameter int num_bits       = 32
);
    localparam int src_w = num_requesters > 1 ? $clog2(num_requesters) : 1;
    logic [num_requesters-1:0]          req_valid;
    logic [num_requesters*num_bits-1:0] req_data;
    logic [num_requesters-1:0]          req_ready;
    logic [num_bits-1:0]                xfer_data;
    logic [src_w-1:0]                   xfer_src;
    logic                               xfer_req;
    logic                               xfer_ack_sync;
    logic                               busy;
    logic                               timeout_err;
    modport slave (
        input  req_valid, req_data, xfer_ack_sync,
        output req_ready, xfer_data, xfer_src, xfer_req, busy, timeout_err
    );
    modport master (
        output req_valid, req_data, xfer_ack_sync,
        input  req_ready, xfer_data, xfer_src, xfer_req, busy, timeout_err
    );
endinterface

// File: rtl/cdc_xfer_arbiter.sv
// cdc_xfer_arbiter: round-robin sharing of one toggle-handshake clock-crossing channel
module cdc_xfer_arbiter #(
    parameter int num_requesters = 4,
    parameter int num_bits       = 32,
    parameter int ack_timeout    = 0
) (
    input  logic clk,
    input  logic reset,
    cdc_xfer_arbiter_if.slave bus
);
    localparam int sw = num_requesters > 1 ? $clog2(num_requesters) : 1;
    localparam int cw = $clog2(ack_timeout + 2);
    localparam logic [cw-1:0] cnt_max = cw'(ack_timeout);
    localparam logic [cw-1:0] cnt_hit = cw'(ack_timeout > 0 ? ack_timeout - 1 : 0);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SETTLE   = 2'd1;
    localparam logic [1:0] WAIT_ACK = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [sw-1:0]       rr_q, rr_d;
    logic [num_bits-1:0] data_q, data_d;
    logic [sw-1:0]       src_q, src_d;
    logic                req_q, req_d;
    logic [cw-1:0]       cnt_q, cnt_d;
    logic                tout_q, tout_d;
    logic [sw-1:0]       idx, gnt;
    logic                any;

    // rotating priority search: first pending requester at or above rr, with wrap
    always_comb begin
        idx = '0;
        gnt = '0;
        any = 1'b0;
        for (int k = 0; k < num_requesters; k++) begin
            idx = sw'((int'(rr_q) + k) % num_requesters);
            if (!any && bus.req_valid[idx]) begin
                any = 1'b1;
                gnt = idx;
            end
        end
    end

    // next-state: grant/latch in IDLE, toggle req after SETTLE, wait for matching ack
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        data_d  = data_q;
        src_d   = src_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        tout_d  = 1'b0;
        if (state_q == IDLE && any) begin
            data_d  = bus.req_data[int'(gnt)*num_bits +: num_bits];
            src_d   = gnt;
            rr_d    = sw'((int'(gnt) + 1) % num_requesters);
            state_d = SETTLE;
        end else if (state_q == SETTLE) begin
            req_d   = ~req_q;
            cnt_d   = '0;
            state_d = WAIT_ACK;
        end else if (state_q == WAIT_ACK) begin
            if (bus.xfer_ack_sync == req_q) begin
                state_d = IDLE;
            end else begin
                cnt_d  = cnt_q == cnt_max ? cnt_q : cnt_q + 1'b1;
                tout_d = ack_timeout != 0 && cnt_q == cnt_hit;
            end
        end
    end

    // state registers; reset restarts the toggle at 0 together with the destination side
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            data_q  <= '0;
            src_q   <= '0;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            data_q  <= data_d;
            src_q   <= src_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
        end
    end

    assign bus.req_ready   = (state_q == IDLE && any) ? num_requesters'(1) << gnt : '0;
    assign bus.xfer_data   = data_q;
    assign bus.xfer_src    = src_q;
    assign bus.xfer_req    = req_q;
    assign bus.busy        = state_q != IDLE;
    assign bus.timeout_err = tout_q;
endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// tb_cdc_xfer_arbiter: randomized transfers checked against a transaction-level model
module tb_cdc_xfer_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int errors = 0;
    int checks = 0;
    int rr_m = 0;
    logic par = 1'b0;
    logic [W-1:0] words [N];
    logic [W-1:0] last_data = '0;
    int last_src = 0;

    cdc_xfer_arbiter_if #(.num_requesters(N), .num_bits(W)) bus ();
    cdc_xfer_arbiter #(.num_requesters(N), .num_bits(W), .ack_timeout(TO)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [N-1:0] m, input int r);
        for (int k = 0; k < N; k++)
            if (m[(r + k) % N]) return (r + k) % N;
        return -1;
    endfunction

    task automatic idle_outputs(input string tag);
        check({tag, "_ready"}, bus.req_ready, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_req"}, bus.xfer_req, 0);
        check({tag, "_data"}, bus.xfer_data, 0);
        check({tag, "_src"}, bus.xfer_src, 0);
        check({tag, "_tout"}, bus.timeout_err, 0);
    endtask

    task automatic do_reset;
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.xfer_ack_sync = 1'b0;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        rr_m = 0;
        par = 1'b0;
        last_data = '0;
        last_src = 0;
        idle_outputs("rst");
    endtask

    task automatic xfer(input logic [N-1:0] mask, input int delay, input logic [W-1:0] d0);
        int g;
        g = pick(mask, rr_m);
        for (int i = 0; i < N; i++) begin
            words[i] = i == 0 ? d0 : $urandom;
            bus.req_data[i*W +: W] = words[i];
        end
        bus.req_valid = mask;
        #1;
        check("ready", bus.req_ready, 64'(1) << g);
        check("busy_idle", bus.busy, 0);
        tick;
        check("data", bus.xfer_data, words[g]);
        check("src", bus.xfer_src, g);
        check("req_hold", bus.xfer_req, par);
        check("ready_settle", bus.req_ready, 0);
        check("busy_settle", bus.busy, 1);
        tick;
        par = ~par;
        check("req_toggle", bus.xfer_req, par);
        for (int i = 0; i < delay; i++) begin
            check("tout", bus.timeout_err, i == TO);
            check("data_hold", bus.xfer_data, words[g]);
            check("ready_wait", bus.req_ready, 0);
            tick;
        end
        check("tout_last", bus.timeout_err, delay == TO);
        bus.xfer_ack_sync = par;
        tick;
        check("busy_done", bus.busy, 0);
        check("tout_done", bus.timeout_err, 0);
        rr_m = (g + 1) % N;
        last_data = words[g];
        last_src = g;
    endtask

    initial begin
        do_reset;
        xfer(4'b0001, 0, 32'hA5A5_0001);

        do_reset;
        repeat (8) xfer(4'b1111, 0, $urandom);

        xfer(4'b0010, 0, $urandom);
        xfer(4'b0011, 0, $urandom);
        xfer(4'b0011, 0, $urandom);

        xfer(4'b0001, 20, $urandom);

        bus.req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            bus.xfer_ack_sync = ~bus.xfer_ack_sync;
            tick;
            check("spur_busy", bus.busy, 0);
            check("spur_req", bus.xfer_req, par);
            check("spur_data", bus.xfer_data, last_data);
            check("spur_src", bus.xfer_src, last_src);
            check("spur_ready", bus.req_ready, 0);
        end

        repeat (30) xfer(4'($urandom_range(1, 15)), int'($urandom_range(0, 7)), $urandom);

        if (par) xfer(4'b0100, 0, $urandom);
        bus.req_valid = 4'b0001;
        tick;
        bus.req_valid = '0;
        tick;
        check("pre_rst_req", bus.xfer_req, 1);
        #2;
        reset = 1'b1;
        bus.xfer_ack_sync = 1'b0;
        #1;
        idle_outputs("async");
        #2;
        reset = 1'b0;
        rr_m = 0;
        par = 1'b0;
        tick;
        check("post_rst_ready", bus.req_ready, 0);
        check("post_rst_busy", bus.busy, 0);
        xfer(4'b1001, 0, $urandom);
        xfer(4'b1001, 2, $urandom);
        bus.req_valid = '0;
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
